id_emitter: RTL and testbench

//   Generates an ASCII character stream that forms one identifier per request:
//   a letter prefix, then the decimal digits of a binary number, then a separator.
//   It is the transmit side of the identifier recogniser. Its stream feeds the
//   8-bit-per-clock char input that the recogniser samples.
//   It converts binary to decimal sequentially (shift-add-3), then serialises
//   one char per accepted beat under valid/ready backpressure.

---
 rtl/id_emitter.sv | 151 +++++++++++++++
 tb/tb_id_emitter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/id_emitter.sv
// Identifier transmitter: converts a binary number to BCD by double dabble, then
// serialises prefix, decimal digits (no leading zeros) and a separator under valid/ready.
module id_emitter #(
    parameter int          NUM_W  = 16,
    parameter int          DIGITS = 5,
    parameter logic [7:0]  SEP    = 8'h20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       prefix,
    input  logic [NUM_W-1:0] num,
    output logic             busy,
    output logic [7:0]       char_out,
    output logic             char_valid,
    input  logic             char_ready,
    output logic             done,
    output logic             err
);
    // state  | meaning
    // S_IDLE | waiting for start; validates prefix
    // S_CONV | NUM_W double-dabble shift cycles
    // S_PFX  | presenting prefix char
    // S_DIG  | presenting decimal digits, most significant first
    // S_SEP  | presenting separator char

    localparam int BCD_W = 4 * DIGITS;
    localparam int DD_W  = BCD_W + NUM_W;
    localparam int CNT_W = $clog2(NUM_W + 1);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [2:0] {S_IDLE, S_CONV, S_PFX, S_DIG, S_SEP} state_t;

    state_t           state, state_nxt;
    logic [7:0]       pfx_q;
    logic [DD_W-1:0]  dd_q, dd_adj;
    logic [BCD_W-1:0] bcd;
    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0] dig_q, top_idx;
    logic [3:0]       cur_nib;
    logic             done_q, err_q;
    logic             alpha, hs;

    assign alpha = ((prefix >= 8'h41) && (prefix <= 8'h5A)) ||
                   ((prefix >= 8'h61) && (prefix <= 8'h7A));
    assign hs    = char_valid && char_ready;
    assign bcd   = dd_q[DD_W-1 -: BCD_W];
    assign done  = done_q;
    assign err   = err_q;

    // BCD digits and binary shift bits live in one register so a plain shift moves both
    always_comb begin
        dd_adj = dd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (dd_q[NUM_W + 4*i +: 4] >= 4'd5)
                dd_adj[NUM_W + 4*i +: 4] = dd_q[NUM_W + 4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        top_idx = '0;
        cur_nib = 4'h0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] != 4'h0)
                top_idx = IDX_W'(i);
            if (dig_q == IDX_W'(i))
                cur_nib = bcd[4*i +: 4];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        busy       = 1'b1;
        char_valid = 1'b0;
        char_out   = 8'h00;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start && alpha)
                    state_nxt = S_CONV;
            end
            S_CONV: begin
                if (cnt_q == '0)
                    state_nxt = S_PFX;
            end
            S_PFX: begin
                char_valid = 1'b1;
                char_out   = pfx_q;
                if (hs)
                    state_nxt = S_DIG;
            end
            S_DIG: begin
                char_valid = 1'b1;
                char_out   = 8'h30 + {4'h0, cur_nib};
                if (hs && (dig_q == '0))
                    state_nxt = S_SEP;
            end
            S_SEP: begin
                char_valid = 1'b1;
                char_out   = SEP;
                if (hs)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pfx_q  <= 8'h00;
            dd_q   <= '0;
            cnt_q  <= '0;
            dig_q  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= (state == S_SEP) && hs;
            err_q  <= (state == S_IDLE) && start && !alpha;
            case (state)
                S_IDLE: begin
                    if (start && alpha) begin
                        pfx_q <= prefix;
                        dd_q  <= {{BCD_W{1'b0}}, num};
                        cnt_q <= CNT_W'(NUM_W - 1);
                    end
                end
                S_CONV: begin
                    dd_q <= dd_adj << 1;
                    if (cnt_q != '0)
                        cnt_q <= cnt_q - 1'b1;
                end
                S_PFX: begin
                    if (hs)
                        dig_q <= top_idx;
                end
                S_DIG: begin
                    if (hs && (dig_q != '0))
                        dig_q <= dig_q - 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_id_emitter.sv
// Directed bench for id_emitter: checks streams, latency, stalls, err, reset abort, back-to-back.
module tb_id_emitter;
    localparam int NUM_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [7:0]       prefix = 8'h00;
    logic [NUM_W-1:0] num = '0;
    logic             char_ready = 1'b0;
    logic             busy, char_valid, done, err;
    logic [7:0]       char_out;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] got[32];
    int got_n, lat, stall_bad, done_seen, err_seen;

    id_emitter #(.NUM_W(NUM_W), .DIGITS(5), .SEP(8'h20)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .prefix(prefix), .num(num),
        .busy(busy), .char_out(char_out), .char_valid(char_valid),
        .char_ready(char_ready), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Issues a request (unless start is already set by the caller) and records
    // accepted chars; returns #1 after the edge that shows done, or after abort_after chars.
    task automatic run(input logic [7:0] p, input logic [15:0] n, input int mode,
                       input bit issue, input int abort_after, input bit poke);
        logic [7:0] prev_c;
        bit prev_stall;
        int vcyc;
        got_n = 0; lat = -1; stall_bad = 0; done_seen = 0; err_seen = 0;
        prev_stall = 0; vcyc = 0; prev_c = 8'h00;
        if (issue) begin start = 1'b1; prefix = p; num = n; end
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (abort_after > 0 && got_n == abort_after) return;
            if (poke && k == 3) begin start = 1'b1; prefix = "q"; num = 16'd99; end
            else if (poke && k == 4) start = 1'b0;
            if (err) err_seen++;
            if (done) begin done_seen = 1; return; end
            if (prev_stall && (!char_valid || char_out !== prev_c)) stall_bad++;
            if (char_valid) begin
                if (lat < 0) lat = k;
                char_ready = (mode == 0) ? 1'b1 : (vcyc % 3 == 0);
                vcyc++;
                prev_c = char_out;
                prev_stall = !char_ready;
                if (char_ready && got_n < 32) begin got[got_n] = char_out; got_n++; end
            end else begin
                char_ready = (mode == 0);
                prev_stall = 0;
            end
            @(posedge clk); #1;
        end
        n_cmp++; n_bad++;
        $display("FAIL run_timeout: got %0d chars, no done within 400 cycles", got_n);
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (char_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", char_valid); end
        n_cmp++; if (char_out !== 8'h00) begin n_bad++; $display("FAIL rst_char: got %h want 00", char_out); end
        n_cmp++; if (done !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL rst_done_err: got %b%b want 00", done, err); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_zero();
        string exp = "a0 ";
        run("a", 16'd0, 0, 1, 0, 0);
        n_cmp++; if (got_n != exp.len()) begin n_bad++; $display("FAIL zero_len: got %0d want %0d", got_n, exp.len()); end
        for (int i = 0; i < exp.len(); i++) begin
            n_cmp++;
            if (i >= got_n || got[i] !== exp[i]) begin n_bad++; $display("FAIL zero_char%0d: got %h want %h", i, got[i], exp[i]); end
        end
        n_cmp++; if (lat != NUM_W) begin n_bad++; $display("FAIL zero_latency: got %0d want %0d", lat, NUM_W); end
        n_cmp++; if (done_seen != 1) begin n_bad++; $display("FAIL zero_done: got %0d want 1", done_seen); end
        n_cmp++; if (busy !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL zero_done_idle: busy %b err %b want 0 0", busy, err); end
        @(posedge clk); #1;
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL zero_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_max();
        string exp = "Z65535 ";
        run("Z", 16'd65535, 0, 1, 0, 0);
        n_cmp++; if (got_n != exp.len()) begin n_bad++; $display("FAIL max_len: got %0d want %0d", got_n, exp.len()); end
        for (int i = 0; i < exp.len(); i++) begin
            n_cmp++;
            if (i >= got_n || got[i] !== exp[i]) begin n_bad++; $display("FAIL max_char%0d: got %h want %h", i, got[i], exp[i]); end
        end
        n_cmp++; if (done_seen != 1 || err_seen != 0) begin n_bad++; $display("FAIL max_done: done %0d err %0d want 1 0", done_seen, err_seen); end
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        string exp = "b1203 ";
        run("b", 16'd1203, 1, 1, 0, 0);
        n_cmp++; if (got_n != exp.len()) begin n_bad++; $display("FAIL stall_len: got %0d want %0d", got_n, exp.len()); end
        for (int i = 0; i < exp.len(); i++) begin
            n_cmp++;
            if (i >= got_n || got[i] !== exp[i]) begin n_bad++; $display("FAIL stall_char%0d: got %h want %h", i, got[i], exp[i]); end
        end
        n_cmp++; if (stall_bad != 0) begin n_bad++; $display("FAIL stall_hold: got %0d unstable cycles want 0", stall_bad); end
        n_cmp++; if (done_seen != 1) begin n_bad++; $display("FAIL stall_done: got %0d want 1", done_seen); end
        char_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_err();
        logic [7:0] bad[3];
        bad[0] = 8'h37; bad[1] = 8'h5B; bad[2] = 8'h60;
        for (int i = 0; i < 3; i++) begin
            start = 1'b1; prefix = bad[i]; num = 16'd5;
            @(posedge clk); #1;
            start = 1'b0;
            n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_pulse_%h: got %b want 1", bad[i], err); end
            n_cmp++; if (busy !== 1'b0 || char_valid !== 1'b0 || done !== 1'b0) begin
                n_bad++; $display("FAIL err_idle_%h: busy %b valid %b done %b want 0 0 0", bad[i], busy, char_valid, done); end
            @(posedge clk); #1;
            n_cmp++; if (err !== 1'b0 || busy !== 1'b0 || char_valid !== 1'b0) begin
                n_bad++; $display("FAIL err_after_%h: err %b busy %b valid %b want 0 0 0", bad[i], err, busy, char_valid); end
        end
    endtask

    task automatic test_reset_mid();
        string exp = "k42 ";
        int done_bad;
        run("k", 16'd42, 0, 1, 2, 0);
        n_cmp++; if (got_n != 2 || got[0] !== "k" || got[1] !== "4") begin
            n_bad++; $display("FAIL rmid_prefix: got %0d chars %h %h want 2 6b 34", got_n, got[0], got[1]); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0 || char_valid !== 1'b0 || char_out !== 8'h00) begin
            n_bad++; $display("FAIL rmid_idle: busy %b valid %b char %h want 0 0 00", busy, char_valid, char_out); end
        done_bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || char_valid !== 1'b0) done_bad++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) done_bad++;
        end
        n_cmp++; if (done_bad != 0) begin n_bad++; $display("FAIL rmid_no_done: got %0d bad cycles want 0", done_bad); end
        run("k", 16'd42, 0, 1, 0, 0);
        n_cmp++; if (got_n != exp.len()) begin n_bad++; $display("FAIL rmid_len: got %0d want %0d", got_n, exp.len()); end
        for (int i = 0; i < exp.len(); i++) begin
            n_cmp++;
            if (i >= got_n || got[i] !== exp[i]) begin n_bad++; $display("FAIL rmid_char%0d: got %h want %h", i, got[i], exp[i]); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        string exp1 = "c7 ";
        string exp2 = "d305 ";
        run("c", 16'd7, 0, 1, 0, 1);
        n_cmp++; if (got_n != exp1.len()) begin n_bad++; $display("FAIL b2b_first_len: got %0d want %0d", got_n, exp1.len()); end
        for (int i = 0; i < exp1.len(); i++) begin
            n_cmp++;
            if (i >= got_n || got[i] !== exp1[i]) begin n_bad++; $display("FAIL b2b_first_char%0d: got %h want %h", i, got[i], exp1[i]); end
        end
        n_cmp++; if (done_seen != 1 || busy !== 1'b0) begin n_bad++; $display("FAIL b2b_done: done %0d busy %b want 1 0", done_seen, busy); end
        start = 1'b1; prefix = "d"; num = 16'd305;
        run("d", 16'd305, 0, 0, 0, 0);
        n_cmp++; if (got_n != exp2.len()) begin n_bad++; $display("FAIL b2b_second_len: got %0d want %0d", got_n, exp2.len()); end
        for (int i = 0; i < exp2.len(); i++) begin
            n_cmp++;
            if (i >= got_n || got[i] !== exp2[i]) begin n_bad++; $display("FAIL b2b_second_char%0d: got %h want %h", i, got[i], exp2[i]); end
        end
        n_cmp++; if (lat != NUM_W) begin n_bad++; $display("FAIL b2b_latency: got %0d want %0d", lat, NUM_W); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_zero();
        test_max();
        test_stall();
        test_err();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
